// File: rtl/bsg_dff_reset_pipe_vr_pkg.sv
// Shared helpers for the elastic reset-DFF pipeline.
// Holds the stage-count ceiling and the occupancy popcount used by the top level.
package bsg_dff_reset_pipe_vr_pkg;

  // Largest pipeline depth the occupancy popcount can cover.
  localparam int max_els_lp = 64;

  // Width of the popcount result; wide enough to hold max_els_lp.
  localparam int popcount_width_lp = $clog2(max_els_lp + 1);

  // Counts the set bits of a zero-extended stage-valid vector.
  function automatic logic [popcount_width_lp-1:0] popcount_v(input logic [max_els_lp-1:0] v);
    logic [popcount_width_lp-1:0] total;
    total = '0;
    for (int i = 0; i < max_els_lp; i++) begin
      total = total + popcount_width_lp'(v[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/bsg_dff_reset_en_stage.sv
// One stage of the elastic pipeline: a valid bit plus a data word.
// The valid bit can be cleared on its own (flush) while the data word keeps
// following the normal advance rule. Data only loads when a real beat arrives,
// so bubbles never disturb the stored word.
module bsg_dff_reset_en_stage
  import bsg_dff_reset_pipe_vr_pkg::*;
#(
  parameter int width_p = 84,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear_v,
  input  logic               src_v,
  input  logic [width_p-1:0] src_data,
  output logic               v,
  output logic [width_p-1:0] data
);

  // Valid and data registers; reset wins, flush only touches the valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      v    <= 1'b0;
      data <= reset_val_p;
    end else begin
      if (clear_v) begin
        v <= 1'b0;
      end else if (en) begin
        v <= src_v;
      end
      if (en && src_v) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/bsg_dff_reset_pipe_vr.sv
// Elastic register pipeline with valid/ready input and valid/yumi output.
// Each stage advances when it is empty or when the stage ahead of it advances,
// so empty stages (bubbles) collapse even while the tail is stalled.
// ready_o depends combinationally on yumi_i through the advance chain.
module bsg_dff_reset_pipe_vr
  import bsg_dff_reset_pipe_vr_pkg::*;
#(
  parameter int width_p = 84,
  parameter int els_p = 2,
  parameter logic [width_p-1:0] reset_val_p = '0,
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o
);

  logic [els_p-1:0]   v_r;
  logic [width_p-1:0] data_r   [els_p];
  logic [els_p-1:0]   adv;
  logic [els_p-1:0]   src_v;
  logic [width_p-1:0] src_data [els_p];
  logic [els_p-1:0]   v_n;

  logic [popcount_width_lp-1:0] count_full;
  logic [count_width_lp-1:0]    count_n;

  // Advance chain: a stage moves unless it and every stage ahead are full with no dequeue.
  always_comb begin
    logic all_full;
    adv = '0;
    for (int k = 0; k < els_p; k++) begin
      all_full = 1'b1;
      for (int j = k; j < els_p; j++) begin
        all_full = all_full & v_r[j];
      end
      adv[k] = ~all_full | yumi_i;
    end
  end

  assign ready_o = adv[0] & ~flush_i;

  genvar k;
  generate
    for (k = 0; k < els_p; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign src_v[k]    = v_i & ready_o;
        assign src_data[k] = data_i;
      end else begin : g_body
        assign src_v[k]    = v_r[k-1];
        assign src_data[k] = data_r[k-1];
      end

      bsg_dff_reset_en_stage #(
        .width_p     (width_p),
        .reset_val_p (reset_val_p)
      ) stage (
        .clk      (clk_i),
        .reset    (reset_i),
        .en       (adv[k]),
        .clear_v  (flush_i),
        .src_v    (src_v[k]),
        .src_data (src_data[k]),
        .v        (v_r[k]),
        .data     (data_r[k])
      );
    end
  endgenerate

  assign v_o    = v_r[els_p-1];
  assign data_o = data_r[els_p-1];

  // Predict each stage's next valid bit so the occupancy count stays in step with the stages.
  always_comb begin
    v_n = '0;
    for (int i = 0; i < els_p; i++) begin
      if (flush_i) begin
        v_n[i] = 1'b0;
      end else if (adv[i]) begin
        v_n[i] = src_v[i];
      end else begin
        v_n[i] = v_r[i];
      end
    end
    count_full = popcount_v(max_els_lp'(v_n));
    count_n    = count_full[count_width_lp-1:0];
  end

  // Registered occupancy count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else begin
      count_o <= count_n;
    end
  end

`ifndef SYNTHESIS
  // Flag a dequeue with nothing to dequeue, and parameter choices the design cannot support.
  always_ff @(posedge clk_i) begin
    assert (els_p >= 1 && width_p >= 1 && els_p <= max_els_lp)
      else $error("bsg_dff_reset_pipe_vr: unsupported parameters");
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_dff_reset_pipe_vr: yumi_i asserted while v_o is low");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_dff_reset_pipe_vr.sv
// Directed bench for the elastic reset-DFF pipeline.
// Main instance: width 8, 3 stages, reset value A5. Second instance: width 84, 1 stage.
module tb_bsg_dff_reset_pipe_vr;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       v_in;
  logic [7:0] data_in;
  logic       yumi_man;
  logic       auto_yumi;
  logic       yumi;
  logic       ready;
  logic       v_out;
  logic [7:0] data_out;
  logic [1:0] count;

  logic        v1;
  logic [83:0] d1;
  logic        y1;
  logic        f1;
  logic        ready1;
  logic        vo1;
  logic [83:0] do1;
  logic [0:0]  count1;

  int tests_run;
  int tests_failed;
  logic [7:0] drained[$];

  assign yumi = auto_yumi ? v_out : yumi_man;

  bsg_dff_reset_pipe_vr #(
    .width_p     (8),
    .els_p       (3),
    .reset_val_p (8'hA5)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush),
    .v_i     (v_in),
    .data_i  (data_in),
    .ready_o (ready),
    .v_o     (v_out),
    .data_o  (data_out),
    .yumi_i  (yumi),
    .count_o (count)
  );

  bsg_dff_reset_pipe_vr #(
    .width_p (84),
    .els_p   (1)
  ) dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (f1),
    .v_i     (v1),
    .data_i  (d1),
    .ready_o (ready1),
    .v_o     (vo1),
    .data_o  (do1),
    .yumi_i  (y1),
    .count_o (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Consume whatever the main pipeline holds, recording the order of outputs.
  task automatic drain(input int max_cycles);
    drained.delete();
    auto_yumi = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (v_out === 1'b1) drained.push_back(data_out);
      tick();
    end
    auto_yumi = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; v_in = 1'b1; data_in = 8'h11; yumi_man = 1'b0;
    tick(); tick();
    reset = 1'b0; v_in = 1'b0;
    #1;
    tests_run++; if (v_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_v_o: got %b expected 0", v_out); end
    tests_run++; if (data_out !== 8'hA5) begin tests_failed++; $display("[TB] FAIL reset_data_o: got %h expected a5", data_out); end
    tests_run++; if (count !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
  endtask

  task automatic test_streaming;
    logic [7:0] outs[$];
    int out_cycle[$];
    int max_cnt;
    max_cnt = 0;
    auto_yumi = 1'b1;
    for (int c = 0; c < 10; c++) begin
      v_in = (c < 4);
      data_in = 8'(c + 1);
      #1;
      if (v_out === 1'b1) begin
        outs.push_back(data_out);
        out_cycle.push_back(c);
      end
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    v_in = 1'b0;
    auto_yumi = 1'b0;
    tests_run++; if (outs.size() != 4) begin tests_failed++; $display("[TB] FAIL stream_count_out: got %0d expected 4", outs.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= outs.size()) begin
        tests_failed++; $display("[TB] FAIL stream_beat%0d: missing, expected %h at cycle %0d", i, 8'(i + 1), 3 + i);
      end else if (outs[i] !== 8'(i + 1) || out_cycle[i] != 3 + i) begin
        tests_failed++; $display("[TB] FAIL stream_beat%0d: got %h at cycle %0d expected %h at cycle %0d", i, outs[i], out_cycle[i], 8'(i + 1), 3 + i);
      end
    end
    tests_run++; if (max_cnt != 3) begin tests_failed++; $display("[TB] FAIL stream_peak_count: got %0d expected 3", max_cnt); end
  endtask

  task automatic test_backpressure;
    auto_yumi = 1'b0; yumi_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_in = 1'b1; data_in = 8'(8'h10 * (i + 1));
      tick();
    end
    v_in = 1'b1; data_in = 8'h40;
    #1;
    tests_run++; if (count !== 2'd3) begin tests_failed++; $display("[TB] FAIL bp_full_count: got %0d expected 3", count); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_full_ready: got %b expected 0", ready); end
    tick();
    tests_run++; if (data_out !== 8'h10 || count !== 2'd3) begin tests_failed++; $display("[TB] FAIL bp_stall_hold: got data %h count %0d expected 10 and 3", data_out, count); end
    yumi_man = 1'b1;
    #1;
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_yumi_ready: got %b expected 1", ready); end
    tests_run++; if (data_out !== 8'h10) begin tests_failed++; $display("[TB] FAIL bp_first_out: got %h expected 10", data_out); end
    tick();
    yumi_man = 1'b0; v_in = 1'b0;
    tests_run++; if (count !== 2'd3) begin tests_failed++; $display("[TB] FAIL bp_swap_count: got %0d expected 3", count); end
    drain(6);
    tests_run++;
    if (drained.size() != 3) begin
      tests_failed++; $display("[TB] FAIL bp_order: got %0d beats expected 3", drained.size());
    end else if (drained[0] !== 8'h20 || drained[1] !== 8'h30 || drained[2] !== 8'h40) begin
      tests_failed++; $display("[TB] FAIL bp_order: got %h %h %h expected 20 30 40", drained[0], drained[1], drained[2]);
    end
    tests_run++; if (count !== 2'd0 || v_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_empty: got count %0d v_o %b expected 0 0", count, v_out); end
  endtask

  task automatic test_bubble_collapse;
    auto_yumi = 1'b0; yumi_man = 1'b0;
    v_in = 1'b1; data_in = 8'h55; tick();
    v_in = 1'b0; tick(); tick();
    v_in = 1'b1; data_in = 8'h66; tick();
    v_in = 1'b0; tick(); tick(); tick();
    tests_run++; if (count !== 2'd2) begin tests_failed++; $display("[TB] FAIL bubble_count: got %0d expected 2", count); end
    tests_run++; if (v_out !== 1'b1 || data_out !== 8'h55) begin tests_failed++; $display("[TB] FAIL bubble_head: got v %b data %h expected 1 55", v_out, data_out); end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bubble_ready: got %b expected 1", ready); end
    drain(5);
    tests_run++;
    if (drained.size() != 2) begin
      tests_failed++; $display("[TB] FAIL bubble_order: got %0d beats expected 2", drained.size());
    end else if (drained[0] !== 8'h55 || drained[1] !== 8'h66) begin
      tests_failed++; $display("[TB] FAIL bubble_order: got %h %h expected 55 66", drained[0], drained[1]);
    end
  endtask

  task automatic test_flush;
    auto_yumi = 1'b0; yumi_man = 1'b0;
    v_in = 1'b1; data_in = 8'hA1; tick();
    data_in = 8'hA2; tick();
    data_in = 8'hA3; tick();
    tests_run++; if (count !== 2'd3) begin tests_failed++; $display("[TB] FAIL flush_fill_count: got %0d expected 3", count); end
    flush = 1'b1; v_in = 1'b1; data_in = 8'hFF; yumi_man = 1'b1;
    #1;
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_ready: got %b expected 0", ready); end
    tick();
    flush = 1'b0; v_in = 1'b0; yumi_man = 1'b0;
    tests_run++; if (count !== 2'd0) begin tests_failed++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
    tests_run++; if (v_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_v_o: got %b expected 0", v_out); end
    tests_run++; if (data_out !== 8'hA2) begin tests_failed++; $display("[TB] FAIL flush_data_o: got %h expected a2", data_out); end
    drain(5);
    tests_run++; if (drained.size() != 0) begin tests_failed++; $display("[TB] FAIL flush_no_output: got %0d beats expected 0", drained.size()); end
  endtask

  task automatic test_reset_beats_flush;
    auto_yumi = 1'b0; yumi_man = 1'b0;
    v_in = 1'b1; data_in = 8'hB1; tick();
    data_in = 8'hB2; tick();
    v_in = 1'b0; tick();
    tests_run++; if (count !== 2'd2) begin tests_failed++; $display("[TB] FAIL rbf_pre_count: got %0d expected 2", count); end
    reset = 1'b1; flush = 1'b1; v_in = 1'b1; data_in = 8'h77;
    tick();
    reset = 1'b0; flush = 1'b0; v_in = 1'b0;
    #1;
    tests_run++; if (data_out !== 8'hA5) begin tests_failed++; $display("[TB] FAIL rbf_data_o: got %h expected a5", data_out); end
    tests_run++; if (count !== 2'd0 || v_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rbf_empty: got count %0d v_o %b expected 0 0", count, v_out); end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rbf_ready: got %b expected 1", ready); end
  endtask

  task automatic test_single_stage;
    logic [83:0] x;
    logic [83:0] y;
    x = 84'hABC_DEF0_1234_5678_9ABC;
    y = 84'h123_4567_89AB_CDEF_0F0F;
    f1 = 1'b0; y1 = 1'b0; v1 = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    tests_run++; if (vo1 !== 1'b0 || do1 !== 84'd0 || count1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL s1_reset: got v %b data %h count %0d expected 0 0 0", vo1, do1, count1); end
    tests_run++; if (ready1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL s1_reset_ready: got %b expected 1", ready1); end
    v1 = 1'b1; d1 = x;
    tick();
    tests_run++; if (vo1 !== 1'b1 || do1 !== x || count1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL s1_latency: got v %b data %h count %0d expected 1 %h 1", vo1, do1, count1, x); end
    d1 = y;
    #1;
    tests_run++; if (ready1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL s1_full_ready: got %b expected 0", ready1); end
    tick();
    tests_run++; if (do1 !== x) begin tests_failed++; $display("[TB] FAIL s1_stall_hold: got %h expected %h", do1, x); end
    y1 = 1'b1;
    #1;
    tests_run++; if (ready1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL s1_yumi_ready: got %b expected 1", ready1); end
    tick();
    tests_run++; if (do1 !== y || count1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL s1_swap: got data %h count %0d expected %h 1", do1, count1, y); end
    v1 = 1'b0;
    tick();
    y1 = 1'b0;
    tests_run++; if (vo1 !== 1'b0 || count1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL s1_drain: got v %b count %0d expected 0 0", vo1, count1); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b0; flush = 1'b0; v_in = 1'b0; data_in = 8'h00;
    yumi_man = 1'b0; auto_yumi = 1'b0;
    v1 = 1'b0; d1 = '0; y1 = 1'b0; f1 = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_reset_beats_flush();
    test_single_stage();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
